sort_out_collector: RTL and testbench
=====================================

# sort_out_collector

Downstream stage of the fixed-size float sorter. Captures one frame of N sorted IEEE-754 single-precision values from the sorter's `outP`/`outvalid` stream into an internal buffer, optionally checks that the frame is in ascending order, then drains the frame to a consumer over a valid/ready handshake. It decouples the sorter's free-running output from a consumer that may stall.

## Interface
- `N`, default 8: values per frame; must be ≥2.
- `W`, default 32: data width, IEEE-754 single.
- `clock`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  W  sample from the sorter (`outP`).
- `in_valid`  in  1  sample qualifier from the sorter (`outvalid`); no backpressure.
- `rd_data`  out  W  buffered value at the read pointer.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts `rd_data` this cycle.
- `rd_last`  out  1  current `rd_data` is element N-1.
- `frame_done`  out  1  one-cycle pulse: frame fully captured.
- `order_err`  out  1  captured frame is not ascending (only with `SORT_ORDER_CHECK_EN`).
- `overflow`  out  1  sticky: a sample arrived while draining and was dropped.

## Operation
- Two states: FILL and DRAIN. Buffer is N×W registers, with `wr_ptr` and `rd_ptr` of width clog2(N).
- FILL: `rd_valid` is 0. On `in_valid`, write `mem[wr_ptr]=in_data` and increment `wr_ptr`. When the sample at `wr_ptr==N-1` is accepted:
  - `wr_ptr` returns to 0.
  - State goes to DRAIN.
  - `frame_done` pulses.
- DRAIN:
  - `rd_valid`=1 and `rd_data=mem[rd_ptr]`, a combinational read of registered storage.
  - `rd_last=(rd_ptr==N-1)`.
  - On `rd_valid&&rd_ready`, `rd_ptr` increments.
  - On the handshake with `rd_last`, `rd_ptr` returns to 0 and state goes to FILL.
- `in_valid` during DRAIN: the sample is dropped, `overflow` sets, and the buffer is unchanged. `overflow` clears only on `rst`.
- DRAIN→FILL and the first new sample in the same cycle: the sample is still dropped, because state is DRAIN at that edge.
- `rd_ready` in FILL is ignored.
- Order comparison key:
  - key(x) = x[31] ? ~x : x ^ 32'h8000_0000. This gives an unsigned total order: -0 < +0.
  - NaNs are ordered by bit pattern; no special handling.

## Timing
- Reset values: state=FILL, `wr_ptr`=`rd_ptr`=0, `rd_valid`=0, `rd_last`=0, `frame_done`=0, `order_err`=0, `overflow`=0, `rd_data`=mem[0]. Buffer contents are not reset and are don't-care.
- Capture: one sample per cycle at full rate, with no gaps required. Gaps in `in_valid` are allowed.
- Latency: if the Nth sample is accepted at edge k, then in the cycle after edge k:
  - `frame_done`=1, for that cycle only.
  - `rd_valid`=1 and `rd_data`=element 0.
  - `order_err` is final for the frame.
- Drain with `rd_ready` held at 1 takes N cycles. `rd_valid` falls in the cycle after the last handshake.
- Stall: `rd_data`, `rd_valid` and `rd_last` are stable while `rd_ready`=0.
- `rst` mid-frame or mid-drain: the outputs immediately take their reset values, and the partial frame is discarded.

## Configuration
- `SORT_ORDER_CHECK_EN` defined: a prev-key register and a comparator are built.
  - On each accepted sample with `wr_ptr`≠0: `order_err` is set if key(in_data) < key(prev).
  - The sample with `wr_ptr`==0 clears `order_err`.
  - `order_err` holds through DRAIN until the next frame's first sample.
- Not defined: `order_err` is tied to 0, and no comparator or prev register exists.

## Test plan
- Reset then ascending frame: feed 0xC1200000, 0xC0800000, 0x40000000, 0x40280000, 0x40400000, 0x40800000, 0x40A00000, 0x40E00000 on consecutive cycles → `frame_done` one cycle after the 8th, `rd_ready`=1 reads the same 8 words in order, `rd_last` on 0x40E00000, `order_err`=0.
- Unsorted frame (with `SORT_ORDER_CHECK_EN`): feed 0x40800000, 0x40A00000, 0x40400000, 0xC1200000, 0x40280000, 0x40E00000, 0xC0800000, 0x40000000 → `order_err`=1 at `frame_done`; the next sorted frame clears it on its first sample. Without the macro, `order_err`=0 throughout.
- Consumer stall: toggle `rd_ready` 1,0,0,1… during DRAIN → each word is presented exactly once, `rd_data` is stable during stalls, and 8 handshakes in total.
- Overflow: assert `in_valid` with 0x3F800000 while in DRAIN → `overflow`=1 and stays 1; drained data is unaffected; the following frame captures correctly.
- Signed zero: frame starting 0x00000000 then 0x80000000, rest ascending → `order_err`=1. The reverse order gives `order_err`=0.
- Reset mid-drain: assert `rst` after 3 handshakes → `rd_valid`=0 immediately; the next 8 samples form a fresh frame read from element 0.

Source files
------------

// File: rtl/sort_out_collector.sv
// ============================================================================
//  Module      : sort_out_collector
//  Description : Frame buffer behind the fixed-size float sorter. It captures
//                N samples from the sorter's free-running output stream, then
//                drains them to a consumer over a valid/ready handshake. An
//                optional ascending-order check flags any frame that is out
//                of order.
//  Ports       : clock, rst (async, active high)
//                in_data/in_valid            - sorter output stream (no stall)
//                rd_data/rd_valid/rd_ready   - consumer handshake
//                rd_last                     - rd_data is element N-1
//                frame_done                  - 1-cycle pulse, frame captured
//                order_err                   - frame not ascending
//                overflow                    - sticky, sample dropped in DRAIN
//  Options     : `define SORT_ORDER_CHECK_EN builds the order checker;
//                otherwise order_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_out_collector #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         rd_last,
    output logic         frame_done,
    output logic         order_err,
    output logic         overflow
);

    localparam int                 c_PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N - 1);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_mem [N];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_frame_done;
    logic               r_overflow;

    logic               w_accept;
    logic               w_handshake;

    assign w_accept    = (r_state == ST_FILL) && in_valid;
    assign w_handshake = rd_valid && rd_ready;

    // Storage carries no reset: its contents are meaningless until a
    // complete frame has been captured.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (in_valid) begin
                        if (r_wr_ptr == c_LAST) begin
                            r_wr_ptr     <= '0;
                            r_state      <= ST_DRAIN;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The sorter cannot be stalled, so anything arriving
                    // while the frame is still being read out is lost.
                    // This includes the edge on which DRAIN ends.
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_handshake) begin
                        if (r_rd_ptr == c_LAST) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_FILL;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ONE;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // Outputs decode registered state only, so they hold steady while the
    // consumer stalls.
    assign rd_valid   = (r_state == ST_DRAIN);
    assign rd_data    = r_mem[r_rd_ptr];
    assign rd_last    = rd_valid && (r_rd_ptr == c_LAST);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef SORT_ORDER_CHECK_EN
    // Map IEEE-754 bits onto an unsigned total order: negatives are
    // inverted so larger magnitudes sort lower, positives get the sign bit
    // set so they sit above every negative (-0 < +0).
    function automatic logic [W-1:0] f_key(input logic [W-1:0] x);
        return x[W-1] ? ~x : (x ^ {1'b1, {(W-1){1'b0}}});
    endfunction

    logic [W-1:0] r_prev_key;
    logic         r_order_err;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_prev_key  <= '0;
            r_order_err <= 1'b0;
        end else if (w_accept) begin
            r_prev_key <= f_key(in_data);
            if (r_wr_ptr == '0) begin
                r_order_err <= 1'b0;
            end else if (f_key(in_data) < r_prev_key) begin
                r_order_err <= 1'b1;
            end
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_out_collector.sv
`default_nettype none

module tb_sort_out_collector;

    localparam int N = 8;
    localparam int W = 32;

    typedef logic [W-1:0] frame_t [N];

    logic         clock = 1'b0;
    logic         rst   = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         rd_ready = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         rd_last;
    logic         frame_done;
    logic         order_err;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

`ifdef SORT_ORDER_CHECK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    sort_out_collector #(.N(N), .W(W)) dut (
        .clock      (clock),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .frame_done (frame_done),
        .order_err  (order_err),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (frame level) ----------------
    logic [W-1:0] cur[$];     // samples of the frame being captured
    logic [W-1:0] exp_q[$];   // words still owed to the consumer
    bit m_drain = 1'b0;
    bit m_fd    = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_oerr  = 1'b0;
    int m_hs    = 0;

    // Float ordering by sign/magnitude: any negative (incl. -0) is below any
    // positive; among negatives a larger magnitude is smaller.
    function automatic bit fl_less(logic [W-1:0] a, logic [W-1:0] b);
        if (a[W-1] != b[W-1]) return a[W-1];
        if (!a[W-1]) return a < b;
        return a > b;
    endfunction

    function automatic bit descends(logic [W-1:0] q[$]);
        for (int i = 1; i < q.size(); i++)
            if (fl_less(q[i], q[i-1])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(bit v, logic [W-1:0] d, bit rdy);
        m_fd = 1'b0;
        if (!m_drain) begin
            if (v) begin
                cur.push_back(d);
                if (c_CHK) m_oerr = descends(cur);
                if (cur.size() == N) begin
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    cur.delete();
                    m_drain = 1'b1;
                    m_fd    = 1'b1;
                    m_hs    = 0;
                end
            end
        end else begin
            if (v) m_ovf = 1'b1;
            if (rdy) begin
                m_hs++;
                if (m_hs == N) m_drain = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        m_drain = 1'b0;
        m_fd    = 1'b0;
        m_ovf   = 1'b0;
        m_oerr  = 1'b0;
        m_hs    = 0;
    endtask

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (armed && !rst) begin
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_drain});
            chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            chk("order_err", {31'b0, order_err}, {31'b0, m_oerr});
            if (rd_valid && m_drain) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=%h expected=none", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_q[0]);
                    chk("rd_last", {31'b0, rd_last}, {31'b0, exp_q.size() == 1});
                    if (rd_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(bit v, logic [W-1:0] d, bit rdy);
        in_valid = v;
        in_data  = d;
        rd_ready = rdy;
        @(posedge clock);
        model_edge(v, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_last", {31'b0, rd_last}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_order_err", {31'b0, order_err}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic feed(frame_t f, int cnt, int gap_pct);
        for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(99) < gap_pct)
                cycle(1'b0, $urandom, 1'($urandom_range(1)));
            cycle(1'b1, f[i], 1'($urandom_range(1)));
        end
    endtask

    // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random
    task automatic drain(int mode, int inj_pct, int max_hs, output int hs);
        int budget;
        int idx;
        bit rdy;
        bit v;
        budget = 200;
        idx    = 0;
        hs     = 0;
        while (m_drain && m_hs < max_hs) begin
            if (budget == 0) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout actual=%0d expected=%0d handshakes", m_hs, N);
                return;
            end
            budget--;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (idx % 3 == 0);
                default: rdy = 1'($urandom_range(1));
            endcase
            v = ($urandom_range(99) < inj_pct);
            if (rd_valid && rdy) hs++;
            cycle(v, 32'h3F80_0000, rdy);
            idx++;
        end
    endtask

    function automatic frame_t rand_frame(bit sorted);
        frame_t f;
        logic [W-1:0] t;
        foreach (f[i]) begin
            case ($urandom_range(5))
                0:       f[i] = 32'h0000_0000;
                1:       f[i] = 32'h8000_0000;
                default: f[i] = $urandom;
            endcase
        end
        if (sorted)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N - 1 - i; j++)
                    if (fl_less(f[j+1], f[j])) begin
                        t = f[j]; f[j] = f[j+1]; f[j+1] = t;
                    end
        return f;
    endfunction

    initial begin
        frame_t f;
        int hs;
        #1;
        do_reset();
        armed = 1'b1;

        // ascending frame, full-rate capture and drain
        f = '{32'hC120_0000, 32'hC080_0000, 32'h4000_0000, 32'h4028_0000,
              32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40E0_0000};
        feed(f, N, 0);
        chk("asc_frame_done", {31'b0, frame_done}, 32'd1);
        chk("asc_first_word", rd_data, 32'hC120_0000);
        chk("asc_order_err", {31'b0, order_err}, 32'd0);
        drain(0, 0, N, hs);
        chk("asc_handshakes", hs, N);
        chk("asc_valid_fall", {31'b0, rd_valid}, 32'd0);

        // unsorted frame
        f = '{32'h4080_0000, 32'h40A0_0000, 32'h4040_0000, 32'hC120_0000,
              32'h4028_0000, 32'h40E0_0000, 32'hC080_0000, 32'h4000_0000};
        feed(f, N, 0);
        chk("unsorted_order_err", {31'b0, order_err}, {31'b0, c_CHK});
        // consumer stall pattern
        drain(1, 0, N, hs);
        chk("stall_handshakes", hs, N);
        // next sorted frame clears order_err on its first sample
        f = '{32'hC120_0000, 32'hC080_0000, 32'h4000_0000, 32'h4028_0000,
              32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40E0_0000};
        feed(f, 1, 0);
        chk("clear_order_err", {31'b0, order_err}, 32'd0);
        feed('{f[1], f[2], f[3], f[4], f[5], f[6], f[7], f[7]}, N - 1, 0);
        // overflow while draining
        drain(2, 100, N, hs);
        chk("overflow_set", {31'b0, overflow}, 32'd1);

        // signed zero: +0 then -0 is descending
        f = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4000_0000,
              32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        feed(f, N, 25);
        chk("zero_desc_order_err", {31'b0, order_err}, {31'b0, c_CHK});
        chk("overflow_sticky", {31'b0, overflow}, 32'd1);
        drain(0, 0, N, hs);
        f[0] = 32'h8000_0000;
        f[1] = 32'h0000_0000;
        feed(f, N, 25);
        chk("zero_asc_order_err", {31'b0, order_err}, 32'd0);

        // reset after 3 handshakes, then a fresh frame
        drain(0, 0, 3, hs);
        do_reset();
        f = rand_frame(1'b1);
        feed(f, N, 0);
        chk("post_rst_first_word", rd_data, f[0]);
        drain(2, 0, N, hs);
        chk("post_rst_handshakes", hs, N);

        // randomized frames
        for (int r = 0; r < 30; r++) begin
            f = rand_frame(r % 2 == 0);
            if (r % 9 == 5) begin
                feed(f, 3, 30);
                do_reset();
            end
            feed(f, N, 30);
            if (r % 7 == 3) begin
                drain(2, 0, 1 + (r % 5), hs);
                do_reset();
            end else begin
                drain(2, (r % 4 == 1) ? 20 : 0, N, hs);
            end
        end

        repeat (3) cycle(1'b0, '0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
